packet_deframer: RTL

PACKET_DEFRAMER -- requirements
Module: packet_deframer

---
 rtl/packet_deframer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/packet_deframer.sv
// Byte-stuffed link deframer: 0x7E flags, 0x7D escapes, fixed-length frames
// decoded into {x_dest, y_dest, payload} and queued in a small FWFT FIFO.
module packet_deframer #(
    parameter int PAYLOAD_SIZE = 4,
    parameter int COORD_W      = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [7:0]                in_byte,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [COORD_W-1:0]        pkt_x_dest,
    output logic [COORD_W-1:0]        pkt_y_dest,
    output logic [PAYLOAD_SIZE*8-1:0] pkt_payload,
    output logic                      err_valid,
    output logic [2:0]                err_code,
    output logic [15:0]               drop_cnt
);

    localparam int PW = PAYLOAD_SIZE * 8;
    localparam int CW = $clog2(PAYLOAD_SIZE + 2);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] ESC  = 2'd2;

    localparam logic [7:0] FLAG_B = 8'h7E;
    localparam logic [7:0] ESC_B  = 8'h7D;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_SHORT    = 3'd1;
    localparam logic [2:0] ERR_LONG     = 3'd2;
    localparam logic [2:0] ERR_ABORT    = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;

    localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_SIZE + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    dest_q;
    logic [PW-1:0] pay_q;
    logic          is_data, store;
    logic [7:0]    data_byte;
    logic          commit, push, pop, full;
    logic [2:0]    ev_code;
    logic [AW:0]   wr_ptr, rd_ptr;

    logic [COORD_W-1:0] mem_x [FIFO_DEPTH];
    logic [COORD_W-1:0] mem_y [FIFO_DEPTH];
    logic [PW-1:0]      mem_p [FIFO_DEPTH];

    assign pkt_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = pkt_valid && pkt_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_data   = 1'b0;
        data_byte = in_byte;
        commit    = 1'b0;
        ev_code   = ERR_NONE;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_byte == FLAG_B) begin
                        state_d = RECV;
                        cnt_d   = '0;
                    end
                end
                RECV: begin
                    if (in_byte == FLAG_B) begin
                        cnt_d = '0;
                        if (cnt_q == LAST_CNT)
                            commit = 1'b1;
                        else if (cnt_q != '0)
                            ev_code = ERR_SHORT;
                    end else if (in_byte == ESC_B) begin
                        state_d = ESC;
                    end else begin
                        is_data = 1'b1;
                    end
                end
                ESC: begin
                    state_d = RECV;
                    if (in_byte == FLAG_B) begin
                        ev_code = ERR_ABORT;
                        cnt_d   = '0;
                    end else begin
                        is_data   = 1'b1;
                        data_byte = in_byte ^ 8'h20;
                    end
                end
                default: state_d = HUNT;
            endcase
            // Escaped bytes count as data, so they can also overrun the frame.
            if (is_data && cnt_q == LAST_CNT) begin
                ev_code = ERR_LONG;
                state_d = HUNT;
                cnt_d   = '0;
            end else if (is_data) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A full FIFO still accepts the commit when the head leaves this cycle.
        push = commit && (!full || pop);
        if (commit && full && !pop)
            ev_code = ERR_OVERFLOW;
    end

    assign store = is_data && (cnt_q != LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            dest_q    <= '0;
            pay_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            drop_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            if (store) begin
                if (cnt_q == '0)
                    dest_q <= data_byte;
                else
                    pay_q <= (pay_q << 8) | PW'(data_byte);
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            err_valid <= (ev_code != ERR_NONE);
            err_code  <= ev_code;
            if (ev_code != ERR_NONE && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr[AW-1:0]] <= COORD_W'(dest_q[7:4]);
            mem_y[wr_ptr[AW-1:0]] <= COORD_W'(dest_q[3:0]);
            mem_p[wr_ptr[AW-1:0]] <= pay_q;
        end
    end

    // Head fields read as zero whenever the FIFO is empty, including in reset.
    assign pkt_x_dest  = pkt_valid ? mem_x[rd_ptr[AW-1:0]] : '0;
    assign pkt_y_dest  = pkt_valid ? mem_y[rd_ptr[AW-1:0]] : '0;
    assign pkt_payload = pkt_valid ? mem_p[rd_ptr[AW-1:0]] : '0;

endmodule
